// File: rtl/fetch_bundle_queue.sv
// Decoupling FIFO between fetch and the bundle parser. Each accepted bundle is
// stamped with its starting major instruction ID from a running counter.
module fetch_bundle_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int bundleSize              = 4 * instructionWidth,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int queueDepth              = 4,
  parameter int ptrWidth                = $clog2(queueDepth)
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  input  logic [0:bundleSize-1]              fetchBundle_i,
  input  logic [addressWidth-1:0]            fetchAddress_i,
  input  logic [1:0]                         fetchLen_i,
  input  logic [PidSize-1:0]                 fetchPid_i,
  input  logic [TidSize-1:0]                 fetchTid_i,
  input  logic                               stall_i,
  output logic                               fetchStall_o,
  output logic                               enable_o,
  output logic [0:bundleSize-1]              bundle_o,
  output logic [addressWidth-1:0]            bundleAddress_o,
  output logic [1:0]                         bundleLen_o,
  output logic [PidSize-1:0]                 bundlePid_o,
  output logic [TidSize-1:0]                 bundleTid_o,
  output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
  output logic [ptrWidth:0]                  count_o
);

  localparam int CntW = ptrWidth + 1;

  typedef struct packed {
    logic [0:bundleSize-1]              bundle;
    logic [addressWidth-1:0]            address;
    logic [1:0]                         len;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] majId;
  } entry_t;

  entry_t                               mem_q [queueDepth];
  entry_t                               out_q, out_d, entry_in;
  logic [ptrWidth-1:0]                  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntW-1:0]                      count_q, count_d;
  logic [instructionCounterWidth-1:0]   majCtr_q, majCtr_d;
  logic                                 enable_q, enable_d;
  logic                                 full, enq, deq;

  assign full = (count_q == CntW'(queueDepth));
  assign enq  = fetchValid_i && !full;
  assign deq  = (count_q != '0) && !stall_i;

  assign entry_in = '{bundle:  fetchBundle_i,
                      address: fetchAddress_i,
                      len:     fetchLen_i,
                      pid:     fetchPid_i,
                      tid:     fetchTid_i,
                      majId:   majCtr_q};

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    majCtr_d = majCtr_q;
    enable_d = 1'b0;
    out_d    = out_q;
    // Flush drops pointers and occupancy but keeps majCtr so IDs stay unique.
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        wrPtr_d  = wrPtr_q + ptrWidth'(1);
        majCtr_d = majCtr_q + instructionCounterWidth'(fetchLen_i)
                 + instructionCounterWidth'(1);
      end
      if (deq) begin
        rdPtr_d  = rdPtr_q + ptrWidth'(1);
        enable_d = 1'b1;
        out_d    = mem_q[rdPtr_q];
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      majCtr_q <= '0;
      enable_q <= 1'b0;
      out_q    <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      majCtr_q <= majCtr_d;
      enable_q <= enable_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i && !flush_i && enq) begin
      mem_q[wrPtr_q] <= entry_in;
    end
  end

  assign fetchStall_o       = full;
  assign enable_o           = enable_q;
  assign bundle_o           = out_q.bundle;
  assign bundleAddress_o    = out_q.address;
  assign bundleLen_o        = out_q.len;
  assign bundlePid_o        = out_q.pid;
  assign bundleTid_o        = out_q.tid;
  assign bundleStartMajId_o = out_q.majId;
  assign count_o            = count_q;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Randomized bench for fetch_bundle_queue against a queue-based reference model,
// preceded by the directed scenarios with fixed expected major IDs.
module tb_fetch_bundle_queue;

  logic           clk = 1'b0;
  logic           rst_b, flush, valid, stall;
  logic [0:127]   bundle;
  logic [63:0]    addr;
  logic [1:0]     len;
  logic [19:0]    pid;
  logic [15:0]    tid;

  logic           fetch_stall, en_o;
  logic [0:127]   bundle_o;
  logic [63:0]    addr_o, majid_o;
  logic [1:0]     len_o;
  logic [19:0]    pid_o;
  logic [15:0]    tid_o;
  logic [2:0]     count_o;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  fetch_bundle_queue dut (
    .clock_i(clk), .reset_i(rst_b), .flush_i(flush), .fetchValid_i(valid),
    .fetchBundle_i(bundle), .fetchAddress_i(addr), .fetchLen_i(len),
    .fetchPid_i(pid), .fetchTid_i(tid), .stall_i(stall),
    .fetchStall_o(fetch_stall), .enable_o(en_o), .bundle_o(bundle_o),
    .bundleAddress_o(addr_o), .bundleLen_o(len_o), .bundlePid_o(pid_o),
    .bundleTid_o(tid_o), .bundleStartMajId_o(majid_o), .count_o(count_o)
  );

  typedef struct {
    logic [127:0] b;
    logic [63:0]  a;
    logic [1:0]   l;
    logic [19:0]  p;
    logic [15:0]  t;
    logic [63:0]  m;
  } ent_t;

  ent_t        mq[$];
  ent_t        eo;
  logic        e_en;
  logic [63:0] mctr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    ent_t n;
    bit   was_full;
    if (!rst_b) begin
      mq.delete();
      mctr = 0;
      eo   = '{default: '0};
      e_en = 1'b0;
    end else if (flush) begin
      mq.delete();
      e_en = 1'b0;
    end else begin
      was_full = (mq.size() == 4);
      if (mq.size() != 0 && !stall) begin
        eo   = mq.pop_front();
        e_en = 1'b1;
      end else begin
        e_en = 1'b0;
      end
      if (valid && !was_full) begin
        n = '{b: bundle, a: addr, l: len, p: pid, t: tid, m: mctr};
        mq.push_back(n);
        mctr = mctr + 64'(len) + 64'd1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("enable", en_o, e_en);
    chk("count", count_o, mq.size());
    chk("fetchStall", fetch_stall, mq.size() == 4);
    chk("bundle", bundle_o, eo.b);
    chk("addr", addr_o, eo.a);
    chk("len", len_o, eo.l);
    chk("pid", pid_o, eo.p);
    chk("tid", tid_o, eo.t);
    chk("majid", majid_o, eo.m);
  endtask

  task automatic drive(input logic v, input logic [1:0] l, input logic s,
                       input logic f, input logic r);
    valid  = v;
    len    = l;
    stall  = s;
    flush  = f;
    rst_b  = r;
    bundle = {$urandom, $urandom, $urandom, $urandom};
    addr   = {$urandom, $urandom};
    pid    = 20'($urandom);
    tid    = 16'($urandom);
  endtask

  initial begin
    eo   = '{default: '0};
    e_en = 1'b0;
    mctr = 0;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();

    // Latency and ID stamping
    drive(1, 3, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp1_en", en_o, 1'b1);
    chk("tp1_majid0", majid_o, 64'd0);
    chk("tp1_len", len_o, 2'd3);
    drive(1, 1, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp1_majid4", majid_o, 64'd4);
    drive(1, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp1_majid6", majid_o, 64'd6);

    // Fill under stall, fifth refused, then drain in order
    drive(0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 1); cycle();
      if (i == 3) chk("tp2_full", fetch_stall, 1'b1);
    end
    chk("tp2_count4", count_o, 3'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1); cycle();
      chk("tp2_drain_en", en_o, 1'b1);
      chk("tp2_drain_id", majid_o, 64'(i));
    end
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp2_idle_en", en_o, 1'b0);
    drive(1, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp2_majid4", majid_o, 64'd4);

    // Steady state at count 2, pointers wrap
    drive(1, 0, 1, 0, 1); cycle();
    drive(1, 2, 1, 0, 1); cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1, 2'($urandom), 0, 0, 1); cycle();
      chk("tp3_count2", count_o, 3'd2);
      chk("tp3_en", en_o, 1'b1);
    end

    // Flush keeps majCtr
    drive(0, 0, 0, 0, 0); cycle();
    drive(1, 3, 1, 0, 1); cycle();
    drive(1, 1, 1, 0, 1); cycle();
    drive(1, 0, 1, 0, 1); cycle();
    drive(1, 2, 0, 1, 1); cycle();
    chk("tp4_count0", count_o, 3'd0);
    chk("tp4_en0", en_o, 1'b0);
    drive(1, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp4_majid7", majid_o, 64'd7);

    // Reset while full
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'($urandom), 1, 0, 1); cycle();
    end
    drive(1, 1, 1, 0, 0); cycle();
    chk("tp5_count0", count_o, 3'd0);
    chk("tp5_majid0", majid_o, 64'd0);
    drive(1, 2, 0, 0, 1); cycle();
    chk("tp5_noby", en_o, 1'b0);
    drive(0, 0, 0, 0, 1); cycle();
    chk("tp5_majid_new", majid_o, 64'd0);

    // Random traffic with phases of heavy and light back-pressure
    for (int i = 0; i < 800; i++) begin
      automatic int sp = ((i / 100) % 2 == 0) ? 70 : 20;
      drive($urandom_range(99) < 70, 2'($urandom),
            $urandom_range(99) < sp,
            $urandom_range(99) < 3,
            !($urandom_range(199) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_bundle_queue.md
# fetch_bundle_queue

Decoupling FIFO between the fetch unit and the bundle parser. It buffers fetched bundles of 1–4 instructions and stamps each accepted bundle with its starting major instruction ID from a running 64-bit counter. It drains one bundle per cycle into the bundle parser's enable/bundle inputs and back-pressures fetch when full. A flush empties the queue without rewinding the ID counter, so major IDs stay unique.

## Interface
- addressWidth, 64, bundle start address width
- instructionWidth, 32, one POWER instruction
- bundleSize, 4*instructionWidth, bundle data width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- queueDepth, 4, entries; power of two, ≥2
- ptrWidth, 2, log2(queueDepth)

Ports:
- clock_i  in  1  single clock, all logic on posedge
- reset_i  in  1  synchronous, active-low reset
- flush_i  in  1  discard all queued bundles
- fetchValid_i  in  1  fetch presents a bundle this cycle
- fetchBundle_i  in  bundleSize  instruction 0 in bits [0:31]
- fetchAddress_i  in  addressWidth  address of instruction 0
- fetchLen_i  in  2  instruction count minus 1
- fetchPid_i  in  PidSize  process ID
- fetchTid_i  in  TidSize  thread ID
- stall_i  in  1  downstream cannot accept a bundle this cycle
- fetchStall_o  out  1  queue full; fetch must hold
- enable_o  out  1  outputs carry a new bundle this cycle
- bundle_o, bundleAddress_o, bundleLen_o, bundlePid_o, bundleTid_o  out  matching widths  head entry fields
- bundleStartMajId_o  out  instructionCounterWidth  major ID of instruction 0
- count_o  out  ptrWidth+1  occupancy

## Operation
- Storage: circular buffer of queueDepth entries.
  - Each entry holds {bundle, address, len, pid, tid, startMajId}.
  - wrPtr and rdPtr wrap modulo queueDepth.
  - count is 0..queueDepth.
- fetchStall_o = (count == queueDepth). It is combinational from the registered count only.
- Enqueue when fetchValid_i && !fetchStall_o.
  - Write the entry at wrPtr with startMajId = majCtr.
  - Then majCtr += fetchLen_i + 1, modulo 2^64; wrap-around is silent.
  - Increment wrPtr.
  - fetchValid_i while full is ignored: nothing is written and majCtr does not change. Fetch must hold its bundle.
- Dequeue when count != 0 && !stall_i.
  - Register the head entry onto the outputs and set enable_o = 1.
  - Increment rdPtr.
- Otherwise enable_o = 0 and the data outputs hold their last values.
- Simultaneous enqueue and dequeue: count unchanged. This is legal at any occupancy below full. At full, the dequeue proceeds and the enqueue is refused, because fetchStall_o was already high.
- No bypass: an empty queue never forwards fetch inputs in the same cycle.
- Priority: reset > flush > normal.
  - Flush: count, wrPtr and rdPtr go to 0 and enable_o goes to 0. Any same-cycle enqueue and dequeue are dropped. majCtr is retained.
- Reset (reset_i == 0 at posedge): count, pointers and majCtr go to 0; every output goes to 0. fetchStall_o is therefore 0.
  - Reset mid-operation discards all contents in that one edge.
- Every registered output is driven from registered state. No path runs from stall_i or fetchValid_i to any output.

## Timing
- Enqueue-to-output latency is 2 edges minimum:
  - A bundle sampled at edge N is stored at N.
  - It appears with enable_o = 1 after edge N+1, provided stall_i = 0 at N+1.
- Throughput is one bundle per cycle in and one out at steady state.
- stall_i sampled high at edge N: enable_o = 0 after N, and the head entry stays queued.
- fetchStall_o rises the cycle after the edge that makes count == queueDepth. It falls the cycle after the first dequeue.
- The flush effect is visible after the flush edge. The first post-flush enqueue can output 2 edges later.

## Test plan
- Reset, enqueue len=3 at edge 1, stall_i=0 -> after edge 2: enable_o=1, bundleStartMajId_o=0, bundleLen_o=3, count_o=0. Next enqueue len=1 -> startMajId 4; following len=0 -> 6.
- stall_i=1, present 5 bundles, each len=0, one per cycle -> first 4 accepted, fetchStall_o=1 after 4th edge, 5th ignored (count_o=4). Drop stall_i -> enable_o=1 for 4 consecutive cycles with majIds 0,1,2,3 in order, then 0. Fetch re-presents the 5th -> majId 4.
- count=2, fetchValid_i=1 and stall_i=0 every cycle for 8 cycles -> count_o stays 2, enable_o=1 each cycle, outputs in FIFO order, pointers wrap twice with no corruption.
- count=3 (majCtr=7), assert flush_i with fetchValid_i=1 -> after edge: count_o=0, enable_o=0, fetchStall_o=0, and the same-cycle bundle is dropped. Next accepted bundle gets majId 7.
- Full queue with stall_i=1, pull reset_i low for one edge -> all outputs 0, count_o=0. Next bundle gets majId 0 and outputs 2 edges after enqueue.
